bist_sequencer: RTL and testbench

Top-level BIST controller for the ALU self-test loop. It seeds and steps the LFSR pattern generator, waits out the ALU/reference-model pipeline latency, and compares the ALU output against the reference-model output for each pattern. It counts mismatches, detects LFSR lock-up (current pattern equal to next pattern), and reports busy, done and pass/fail status to the test access logic.

---
 rtl/bist_sequencer.sv | 169 ++++++++++++++++
 tb/tb_bist_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_sequencer.sv
// bist_sequencer: BIST controller for the ALU self-test loop.
// Latency: SEED->DONE takes 1 + PATTERN_COUNT*(CMP_LATENCY+1) cycles; done rises on the following edge.
// Backpressure: none; start is ignored while busy, abort wins over start, reset wins over both.
//
// Ports:
//   clk, rst_n (sync, active-low), start (pulse), abort (return to IDLE)
//   lfsr_cur/lfsr_nxt   : current and look-ahead LFSR pattern
//   alu_out/ref_out     : ALU-under-test and reference-model results
//   lfsr_load/lfsr_seed : seed load pulse and constant seed value
//   lfsr_step           : advance the LFSR one step
//   busy/done/pass/lockup, fail_count, first_fail_idx, pattern_idx : run status
//   signature           : MISR over alu_out (only with BIST_SIGNATURE_EN defined)
module bist_sequencer #(
  parameter int              DATA_W        = 8,
  parameter int              PATTERN_COUNT = 255,
  parameter logic [DATA_W-1:0] LFSR_SEED   = 8'h01,
  parameter int              CMP_LATENCY   = 1,
  parameter bit              STOP_ON_FAIL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] lfsr_cur,
  input  logic [DATA_W-1:0] lfsr_nxt,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] ref_out,
  output logic              lfsr_load,
  output logic [DATA_W-1:0] lfsr_seed,
  output logic              lfsr_step,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              lockup,
  output logic [15:0]       fail_count,
  output logic [15:0]       first_fail_idx,
`ifdef BIST_SIGNATURE_EN
  output logic [DATA_W-1:0] signature,
`endif
  output logic [15:0]       pattern_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic       mismatch;
  logic       locked;
  logic       last_pattern;

  assign lfsr_seed    = LFSR_SEED;
  assign mismatch     = (alu_out != ref_out);
  assign locked       = (lfsr_cur == lfsr_nxt);
  assign last_pattern = (pattern_idx == 16'(PATTERN_COUNT - 1));

  assign busy = (state == S_SEED) || (state == S_WAIT) || (state == S_COMPARE);
  assign done = (state == S_DONE);
  // fail_count and lockup are already final once DONE is reached.
  assign pass = done && (fail_count == 16'd0) && !lockup;

`ifdef BIST_SIGNATURE_EN
  // Low-order Galois feedback taps (the x^DATA_W term is implicit).
  function automatic logic [DATA_W-1:0] misr_poly();
    case (DATA_W)
      4:       return DATA_W'(32'h0000_0003);
      8:       return DATA_W'(32'h0000_0071);
      16:      return DATA_W'(32'h0000_6801);
      32:      return DATA_W'(32'h0040_0007);
      default: return DATA_W'(32'h0000_0001);
    endcase
  endfunction

  localparam logic [DATA_W-1:0] MISR_POLY = misr_poly();
`endif

  always_comb begin
    state_nxt = state;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_SEED;
      end
      S_SEED: begin
        lfsr_load = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Counter was loaded with CMP_LATENCY, so this is the last WAIT cycle at 1.
        if (wait_cnt <= 4'd1) state_nxt = S_COMPARE;
      end
      S_COMPARE: begin
        if (locked) begin
          state_nxt = S_DONE;
        end else if (mismatch && STOP_ON_FAIL) begin
          state_nxt = S_DONE;
        end else if (last_pattern) begin
          state_nxt = S_DONE;
        end else begin
          lfsr_step = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort or reset suppresses any LFSR pulse on the way back to IDLE.
    if (abort || !rst_n) begin
      state_nxt = S_IDLE;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state          <= S_IDLE;
      wait_cnt       <= 4'd0;
      fail_count     <= 16'd0;
      first_fail_idx <= 16'd0;
      pattern_idx    <= 16'd0;
      lockup         <= 1'b0;
`ifdef BIST_SIGNATURE_EN
      signature      <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            fail_count     <= 16'd0;
            first_fail_idx <= 16'd0;
            pattern_idx    <= 16'd0;
            lockup         <= 1'b0;
`ifdef BIST_SIGNATURE_EN
            signature      <= '0;
`endif
          end
        end
        S_SEED: wait_cnt <= 4'(CMP_LATENCY);
        S_WAIT: wait_cnt <= wait_cnt - 4'd1;
        S_COMPARE: begin
          if (mismatch) begin
            if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
            if (fail_count == 16'd0) first_fail_idx <= pattern_idx;
          end
          if (locked) lockup <= 1'b1;
          if (lfsr_step) begin
            pattern_idx <= pattern_idx + 16'd1;
            wait_cnt    <= 4'(CMP_LATENCY);
          end
`ifdef BIST_SIGNATURE_EN
          signature <= {signature[DATA_W-2:0], 1'b0}
                     ^ (signature[DATA_W-1] ? MISR_POLY : '0)
                     ^ alu_out;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// tb_bist_sequencer: directed bench for bist_sequencer with a small LFSR/ALU environment.
// Latency: checks run-length against 1 + PATTERN_COUNT*(CMP_LATENCY+1) busy cycles.
// Backpressure: n/a; start/abort/reset are driven from the main sequence.
module tb_bist_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, abort, start0, start1;
  logic [7:0] cur0, nxt0, alu0, ref0, cur1, nxt1, alu1, ref1;
  logic load0, step0, busy0, done0, pass0, lock0;
  logic load1, step1, busy1, done1, pass1, lock1;
  logic [7:0] seed0, seed1;
  logic [15:0] fc0, ff0, pi0, fc1, ff1, pi1;
`ifdef BIST_SIGNATURE_EN
  logic [7:0] sig0, sig1;
`endif

  int idx0, idx1, lkidx0, lkidx1;
  logic [3:0] mask0, mask1;
  bit const_alu;

  int checks = 0;
  int errors = 0;

  bist_sequencer #(.DATA_W(8), .PATTERN_COUNT(4), .LFSR_SEED(8'h01), .CMP_LATENCY(1), .STOP_ON_FAIL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
    .lfsr_cur(cur0), .lfsr_nxt(nxt0), .alu_out(alu0), .ref_out(ref0),
    .lfsr_load(load0), .lfsr_seed(seed0), .lfsr_step(step0),
    .busy(busy0), .done(done0), .pass(pass0), .lockup(lock0),
    .fail_count(fc0), .first_fail_idx(ff0),
`ifdef BIST_SIGNATURE_EN
    .signature(sig0),
`endif
    .pattern_idx(pi0)
  );

  bist_sequencer #(.DATA_W(8), .PATTERN_COUNT(4), .LFSR_SEED(8'h01), .CMP_LATENCY(1), .STOP_ON_FAIL(1'b1)) dut_sof (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
    .lfsr_cur(cur1), .lfsr_nxt(nxt1), .alu_out(alu1), .ref_out(ref1),
    .lfsr_load(load1), .lfsr_seed(seed1), .lfsr_step(step1),
    .busy(busy1), .done(done1), .pass(pass1), .lockup(lock1),
    .fail_count(fc1), .first_fail_idx(ff1),
`ifdef BIST_SIGNATURE_EN
    .signature(sig1),
`endif
    .pattern_idx(pi1)
  );

  function automatic logic [7:0] lfsr_f(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Environment: LFSR and a bench-side pattern index driven by the load/step pulses.
  always @(posedge clk) begin
    if (!rst_n) begin
      cur0 <= 8'h00; idx0 <= 0;
    end else if (load0) begin
      cur0 <= seed0; idx0 <= 0;
    end else if (step0) begin
      cur0 <= lfsr_f(cur0); idx0 <= idx0 + 1;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      cur1 <= 8'h00; idx1 <= 0;
    end else if (load1) begin
      cur1 <= seed1; idx1 <= 0;
    end else if (step1) begin
      cur1 <= lfsr_f(cur1); idx1 <= idx1 + 1;
    end
  end

  assign nxt0 = (idx0 == lkidx0) ? cur0 : lfsr_f(cur0);
  assign ref0 = const_alu ? 8'hA5 : (cur0 ^ 8'h3C);
  assign alu0 = ref0 ^ ((idx0 < 4 && mask0[idx0[1:0]]) ? 8'h01 : 8'h00);
  assign nxt1 = (idx1 == lkidx1) ? cur1 : lfsr_f(cur1);
  assign ref1 = cur1 ^ 8'h3C;
  assign alu1 = ref1 ^ ((idx1 < 4 && mask1[idx1[1:0]]) ? 8'h01 : 8'h00);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start on the selected DUT and count busy cycles and LFSR pulses until done.
  task automatic run(input int sel, input bit glitch, output int bz, output int ld, output int st);
    bz = 0; ld = 0; st = 0;
    @(negedge clk);
    if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if ((sel != 0) ? done1 : done0) break;
      bz += int'((sel != 0) ? busy1 : busy0);
      ld += int'((sel != 0) ? load1 : load0);
      st += int'((sel != 0) ? step1 : step0);
      if (glitch && c == 2) begin
        if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
    end
    check("run_done", int'((sel != 0) ? done1 : done0), 1);
  endtask

  task automatic check_idle0(input string tag);
    check({tag, "_busy"}, int'(busy0), 0);
    check({tag, "_done"}, int'(done0), 0);
    check({tag, "_pass"}, int'(pass0), 0);
    check({tag, "_lockup"}, int'(lock0), 0);
    check({tag, "_fail_count"}, int'(fc0), 0);
    check({tag, "_first_fail"}, int'(ff0), 0);
    check({tag, "_pattern_idx"}, int'(pi0), 0);
    check({tag, "_load"}, int'(load0), 0);
    check({tag, "_step"}, int'(step0), 0);
  endtask

  typedef struct {
    logic [3:0] mask;
    int lk;
    bit glitch;
    int fc, ff, ps, lko, pi, bz, st;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bz, ld, st;
    logic [7:0] sig_exp;

    //            mask     lk  glt fc ff ps lk pi bz st
    vecs[0] = '{4'b0000, -1, 1'b1, 0, 0, 1, 0, 3, 9, 3};
    vecs[1] = '{4'b0100, -1, 1'b0, 1, 2, 0, 0, 3, 9, 3};
    vecs[2] = '{4'b0000,  3, 1'b0, 0, 0, 0, 1, 3, 9, 3};
    vecs[3] = '{4'b0010,  1, 1'b1, 1, 1, 0, 1, 1, 5, 1};
    vecs[4] = '{4'b1010, -1, 1'b0, 2, 1, 0, 0, 3, 9, 3};

    rst_n = 1'b0; abort = 1'b0; start0 = 1'b0; start1 = 1'b0;
    mask0 = 4'b0; mask1 = 4'b0; lkidx0 = -1; lkidx1 = -1; const_alu = 1'b0;
    repeat (2) @(negedge clk);
    check_idle0("reset");
    check("reset_seed", int'(seed0), 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mask0 = vecs[i].mask;
      lkidx0 = vecs[i].lk;
      run(0, vecs[i].glitch, bz, ld, st);
      check($sformatf("v%0d_fail_count", i), int'(fc0), vecs[i].fc);
      check($sformatf("v%0d_first_fail", i), int'(ff0), vecs[i].ff);
      check($sformatf("v%0d_pass", i), int'(pass0), vecs[i].ps);
      check($sformatf("v%0d_lockup", i), int'(lock0), vecs[i].lko);
      check($sformatf("v%0d_pattern_idx", i), int'(pi0), vecs[i].pi);
      check($sformatf("v%0d_busy_cycles", i), bz, vecs[i].bz);
      check($sformatf("v%0d_loads", i), ld, 1);
      check($sformatf("v%0d_steps", i), st, vecs[i].st);
      check($sformatf("v%0d_busy_after", i), int'(busy0), 0);
    end
    lkidx0 = -1;

    // DONE holds results across idle cycles.
    repeat (3) @(negedge clk);
    check("hold_done", int'(done0), 1);
    check("hold_fail_count", int'(fc0), 2);

    // Stop-on-fail: mismatch at index 1 ends the run there.
    mask1 = 4'b0010;
    run(1, 1'b0, bz, ld, st);
    check("sof_pattern_idx", int'(pi1), 1);
    check("sof_fail_count", int'(fc1), 1);
    check("sof_first_fail", int'(ff1), 1);
    check("sof_steps", st, 1);
    check("sof_busy_cycles", bz, 5);
    check("sof_pass", int'(pass1), 0);
    check("sof_lockup", int'(lock1), 0);

    // Abort mid-WAIT after a recorded mismatch, then restart two cycles later.
    mask0 = 4'b0001;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", int'(busy0), 1);
    check("pre_abort_fail_count", int'(fc0), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle0("abort");
    repeat (2) @(negedge clk);
    mask0 = 4'b0000;
    run(0, 1'b0, bz, ld, st);
    check("post_abort_pass", int'(pass0), 1);
    check("post_abort_busy_cycles", bz, 9);
    check("post_abort_steps", st, 3);

    // Reset mid-run, then a clean rerun with one mismatch.
    mask0 = 4'b0001;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle0("midreset");
    rst_n = 1'b1;
    mask0 = 4'b1000;
    run(0, 1'b0, bz, ld, st);
    check("post_reset_fail_count", int'(fc0), 1);
    check("post_reset_first_fail", int'(ff0), 3);
    check("post_reset_pass", int'(pass0), 0);
    check("post_reset_busy_cycles", bz, 9);

`ifdef BIST_SIGNATURE_EN
    sig_exp = 8'h00;
    for (int k = 0; k < 4; k++)
      sig_exp = {sig_exp[6:0], 1'b0} ^ (sig_exp[7] ? 8'h71 : 8'h00) ^ 8'hA5;
    const_alu = 1'b1;
    mask0 = 4'b0000;
    run(0, 1'b0, bz, ld, st);
    check("signature_run1", int'(sig0), int'(sig_exp));
    check("signature_pass", int'(pass0), 1);
    run(0, 1'b0, bz, ld, st);
    check("signature_run2", int'(sig0), int'(sig_exp));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("signature_abort", int'(sig0), 0);
    const_alu = 1'b0;
`else
    sig_exp = 8'h00;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
